// File: rtl/frame_scheduler.sv
// Animation timeline sequencer for the SPI frame reader: steps the frame index,
// issues periodic load triggers, waits for each load and counts late loads.
module frame_scheduler #(
  parameter int unsigned PERIOD_W = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                loop,
  input  logic [PERIOD_W-1:0] period,
  input  logic [7:0]          first_frame,
  input  logic [7:0]          last_frame,
  input  logic [23:0]         overlay,
  input  logic                load_done,
  input  logic                clr_overrun,
  output logic                trig,
  output logic [31:0]         frames,
  output logic [7:0]          frame_idx,
  output logic                busy,
  output logic                finished,
  output logic [7:0]          overrun_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, LOAD, COUNT} state_t;

  state_t              state, state_next;
  logic [PERIOD_W-1:0] cnt, cnt_last;
  logic [7:0]          idx_next;
  logic                enable_q, start, at_end, stop, late, done_ok;

  always_comb begin
    cnt_last = (period == '0) ? '0 : period - PERIOD_W'(1);
    at_end   = frame_idx >= last_frame;
    idx_next = at_end ? first_frame : frame_idx + 8'd1;
    stop     = at_end && !loop;
    late     = cnt >= cnt_last;
    // A finished one-shot run only restarts after enable has been seen low.
    start    = enable && (!finished || !enable_q);
    done_ok  = (state == LOAD) && load_done && enable;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = REQ;
      REQ:   state_next = LOAD;
      LOAD:
        if (load_done) begin
          if (!enable || stop) state_next = IDLE;
          else if (late)       state_next = REQ;
          else                 state_next = COUNT;
        end
      COUNT:
        if (!enable)                state_next = IDLE;
        else if (cnt >= cnt_last)   state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    trig = (state == REQ);
    busy = (state == LOAD);
  end

  // The counter is cleared on entry to REQ so it reads 0 during the trig cycle;
  // this makes trig-to-trig spacing equal to the effective period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      frame_idx   <= '0;
      frames      <= '0;
      finished    <= 1'b0;
      overrun_cnt <= '0;
      enable_q    <= 1'b0;
    end else begin
      enable_q <= enable;

      if (state_next == REQ)
        cnt <= '0;
      else if (state != IDLE && cnt != '1)
        cnt <= cnt + PERIOD_W'(1);

      if (state == IDLE && start) begin
        frame_idx <= first_frame;
        finished  <= 1'b0;
      end else if (done_ok) begin
        if (stop) finished  <= 1'b1;
        else      frame_idx <= idx_next;
      end

      if (state == REQ)
        frames <= {overlay, frame_idx};

      if (clr_overrun)
        overrun_cnt <= '0;
      else if (done_ok && late && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: a table of timeline configurations plus
// hand-written one-shot, disable, saturation and async-reset sequences.
module tb_frame_scheduler;

  localparam int unsigned PW = 25;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          loop = 1'b0;
  logic [PW-1:0] period = '0;
  logic [7:0]    first_frame = '0;
  logic [7:0]    last_frame = '0;
  logic [23:0]   overlay = '0;
  logic          load_done = 1'b0;
  logic          clr_overrun = 1'b0;
  logic          trig;
  logic [31:0]   frames;
  logic [7:0]    frame_idx;
  logic          busy;
  logic          finished;
  logic [7:0]    overrun_cnt;

  frame_scheduler #(.PERIOD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .loop(loop), .period(period),
    .first_frame(first_frame), .last_frame(last_frame), .overlay(overlay),
    .load_done(load_done), .clr_overrun(clr_overrun), .trig(trig),
    .frames(frames), .frame_idx(frame_idx), .busy(busy),
    .finished(finished), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  // Reader model: load_done pulses rd_delay cycles after the trig cycle.
  int rd_delay = 10;
  int rd_cnt = 0;
  always @(posedge clk) begin
    #1;
    load_done = 1'b0;
    if (!rst_n) rd_cnt = 0;
    else begin
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) load_done = 1'b1;
      end
      if (trig) rd_cnt = rd_delay;
    end
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    enable      = 1'b0;
    clr_overrun = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = load_done;
    end
    check({name, " load_done seen"}, 64'(seen), 64'd1);
  endtask

  typedef struct {
    logic [PW-1:0] period;
    logic [7:0]    first;
    logic [7:0]    last;
    logic          lp;
    logic [23:0]   ovl;
    int            delay;
    int            gap;
    logic [39:0]   idx;   // expected frame_idx at trig k in bits [8k+:8]
    logic [7:0]    ovr;   // expected overrun_cnt at the 5th trig
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ntrig;
    int last_c;

    vecs[0] = '{period: 20, first: 2,   last: 4,   lp: 1, ovl: 24'h0F5511, delay: 10, gap: 20,
                idx: {8'd3, 8'd2, 8'd4, 8'd3, 8'd2}, ovr: 8'd0};
    vecs[1] = '{period: 8,  first: 1,   last: 3,   lp: 1, ovl: 24'hABCDEF, delay: 12, gap: 13,
                idx: {8'd2, 8'd1, 8'd3, 8'd2, 8'd1}, ovr: 8'd4};
    vecs[2] = '{period: 0,  first: 7,   last: 8,   lp: 1, ovl: 24'h000001, delay: 3,  gap: 4,
                idx: {8'd7, 8'd8, 8'd7, 8'd8, 8'd7}, ovr: 8'd4};
    vecs[3] = '{period: 6,  first: 9,   last: 3,   lp: 1, ovl: 24'h123456, delay: 2,  gap: 6,
                idx: {8'd9, 8'd9, 8'd9, 8'd9, 8'd9}, ovr: 8'd0};
    vecs[4] = '{period: 12, first: 0,   last: 1,   lp: 1, ovl: 24'hFFFFFF, delay: 10, gap: 12,
                idx: {8'd0, 8'd1, 8'd0, 8'd1, 8'd0}, ovr: 8'd0};
    vecs[5] = '{period: 12, first: 0,   last: 1,   lp: 1, ovl: 24'h800000, delay: 11, gap: 12,
                idx: {8'd0, 8'd1, 8'd0, 8'd1, 8'd0}, ovr: 8'd4};
    vecs[6] = '{period: 1,  first: 254, last: 255, lp: 1, ovl: 24'h00FF00, delay: 5,  gap: 6,
                idx: {8'd254, 8'd255, 8'd254, 8'd255, 8'd254}, ovr: 8'd4};

    for (int v = 0; v < 7; v++) begin
      period      = vecs[v].period;
      first_frame = vecs[v].first;
      last_frame  = vecs[v].last;
      loop        = vecs[v].lp;
      overlay     = vecs[v].ovl;
      rd_delay    = vecs[v].delay;
      do_reset();
      check($sformatf("v%0d reset", v),
            64'({trig, busy, finished, overrun_cnt, frame_idx, frames}), 64'd0);
      enable = 1'b1;
      ntrig  = 0;
      last_c = 0;
      for (int c = 0; c < 400 && ntrig < 5; c++) begin
        @(negedge clk);
        if (ntrig == 1 && c == last_c + 1) begin
          check($sformatf("v%0d frames", v), 64'(frames), 64'({vecs[v].ovl, vecs[v].idx[7:0]}));
          check($sformatf("v%0d busy", v), 64'(busy), 64'd1);
        end
        if (trig) begin
          if (ntrig == 0) check($sformatf("v%0d start_latency", v), 64'(c), 64'd0);
          else check($sformatf("v%0d trig_gap%0d", v, ntrig), 64'(c - last_c), 64'(vecs[v].gap));
          check($sformatf("v%0d frame_idx%0d", v, ntrig), 64'(frame_idx),
                64'(vecs[v].idx[8*ntrig +: 8]));
          ntrig++;
          last_c = c;
        end
      end
      check($sformatf("v%0d trig_count", v), 64'(ntrig), 64'd5);
      check($sformatf("v%0d overrun_cnt", v), 64'(overrun_cnt), 64'(vecs[v].ovr));
      enable = 1'b0;
    end

    // One-shot run: two loads, then parked until enable is cycled.
    period = 20; first_frame = 8'd5; last_frame = 8'd6; loop = 1'b0; overlay = '0; rd_delay = 10;
    do_reset();
    enable = 1'b1;
    ntrig  = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (trig) ntrig++;
    end
    check("oneshot trig_count", 64'(ntrig), 64'd2);
    check("oneshot finished", 64'(finished), 64'd1);
    check("oneshot frame_idx", 64'(frame_idx), 64'd6);
    check("oneshot idle", 64'({trig, busy}), 64'd0);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("restart trig", 64'(trig), 64'd1);
    check("restart frame_idx", 64'(frame_idx), 64'd5);
    check("restart finished", 64'(finished), 64'd0);
    enable = 1'b0;

    // Disable three cycles into a load: the load completes, then the block idles.
    period = 20; first_frame = 8'd2; last_frame = 8'd4; loop = 1'b1; rd_delay = 10;
    do_reset();
    enable = 1'b1;
    @(negedge clk);
    check("dis first trig", 64'(trig), 64'd1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 3) enable = 1'b0;
      if (k == 10) check("dis busy at load_done", 64'({busy, load_done}), 64'b11);
      if (k == 11) check("dis busy after load_done", 64'(busy), 64'd0);
    end
    ntrig = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (trig) ntrig++;
    end
    check("dis no trig", 64'(ntrig), 64'd0);
    check("dis frame_idx", 64'(frame_idx), 64'd2);

    // Overrun saturation and clear priority.
    period = 8; first_frame = 8'd0; last_frame = 8'd3; loop = 1'b1; rd_delay = 12;
    do_reset();
    enable = 1'b1;
    ntrig  = 0;
    for (int c = 0; c < 5000 && ntrig < 270; c++) begin
      @(negedge clk);
      if (trig) ntrig++;
    end
    check("sat trig_count", 64'(ntrig), 64'd270);
    check("sat overrun_cnt", 64'(overrun_cnt), 64'd255);
    wait_done("clr");
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("clr overrun_cnt", 64'(overrun_cnt), 64'd0);
    wait_done("prio");
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("clr priority", 64'(overrun_cnt), 64'd0);
    wait_done("post");
    @(negedge clk);
    check("count after clr", 64'(overrun_cnt), 64'd1);
    enable = 1'b0;

    // Asynchronous reset in the middle of a load.
    period = 8; first_frame = 8'd2; last_frame = 8'd4; loop = 1'b1; overlay = 24'h0F5511;
    rd_delay = 12;
    do_reset();
    enable = 1'b1;
    ntrig  = 0;
    for (int c = 0; c < 200 && ntrig < 3; c++) begin
      @(negedge clk);
      if (trig) ntrig++;
    end
    check("arst trig_count", 64'(ntrig), 64'd3);
    repeat (4) @(negedge clk);
    check("arst pre busy/ovr", 64'({busy, overrun_cnt}), 64'({1'b1, 8'd2}));
    #3 rst_n = 1'b0;
    #1;
    check("arst outputs", 64'({trig, busy, finished, overrun_cnt, frame_idx, frames}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst restart trig", 64'(trig), 64'd1);
    check("arst restart frame_idx", 64'(frame_idx), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
